// File: rtl/dotmat_frame_scanner.sv
// Two-colour 16x8 LED matrix frame scanner: accumulates game-core dots into a write
// buffer, commits it to a display buffer once per frame period and scans it row by row.
// Optional inter-row column blanking is enabled by defining DOTMAT_BLANK_EN.
module dotmat_frame_scanner #(
  parameter int SWAP_PERIOD  = 256128,
  parameter int ROW_CYCLES   = 1024,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [9:0]  pixel_in,
  output logic [15:0] ROWOUT,
  output logic [7:0]  COLR,
  output logic [7:0]  COLG,
  output logic        frame_tick
);

  localparam int FW = (SWAP_PERIOD > 1) ? $clog2(SWAP_PERIOD) : 1;
  localparam int CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(SWAP_PERIOD - 1);
  localparam logic [CW-1:0] CCNT_LAST = CW'(ROW_CYCLES - 1);

  logic [FW-1:0]       fcnt;
  logic [CW-1:0]       ccnt;
  logic [CW-1:0]       ccnt_nxt;
  logic [3:0]          row;
  logic [3:0]          row_nxt;
  logic [15:0][7:0]    wbuf_r;
  logic [15:0][7:0]    wbuf_g;
  logic [15:0][7:0]    dbuf_r;
  logic [15:0][7:0]    dbuf_g;
  logic [15:0][7:0]    wbuf_r_nxt;
  logic [15:0][7:0]    wbuf_g_nxt;
  logic                commit;
  logic [3:0]          pix_y;
  logic [2:0]          pix_x;
  logic [7:0]          pix_mask;
  logic                col_on;

  // A dot arriving on the commit cycle lands in the freshly cleared write buffer.
  always_comb begin
    commit     = (fcnt == FCNT_LAST);
    pix_y      = pixel_in[6:3];
    pix_x      = pixel_in[2:0];
    pix_mask   = 8'h01 << pix_x;
    wbuf_r_nxt = commit ? '0 : wbuf_r;
    wbuf_g_nxt = commit ? '0 : wbuf_g;
    if (pixel_in[9]) wbuf_r_nxt[pix_y] = wbuf_r_nxt[pix_y] | pix_mask;
    if (pixel_in[8]) wbuf_g_nxt[pix_y] = wbuf_g_nxt[pix_y] | pix_mask;
  end

  always_comb begin
    if (ccnt == CCNT_LAST) begin
      ccnt_nxt = '0;
      row_nxt  = row + 4'd1;
    end else begin
      ccnt_nxt = ccnt + CW'(1);
      row_nxt  = row;
    end
`ifdef DOTMAT_BLANK_EN
    col_on = (ccnt_nxt >= CW'(BLANK_CYCLES));
`else
    col_on = 1'b1;
`endif
  end

  // Outputs are computed from next-state counters so row and blanking switch on the same edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      fcnt       <= '0;
      ccnt       <= '0;
      row        <= '0;
      wbuf_r     <= '0;
      wbuf_g     <= '0;
      dbuf_r     <= '0;
      dbuf_g     <= '0;
      ROWOUT     <= 16'h0001;
      COLR       <= '0;
      COLG       <= '0;
      frame_tick <= 1'b0;
    end else begin
      fcnt       <= commit ? '0 : fcnt + FW'(1);
      wbuf_r     <= wbuf_r_nxt;
      wbuf_g     <= wbuf_g_nxt;
      if (commit) begin
        dbuf_r <= wbuf_r;
        dbuf_g <= wbuf_g;
      end
      frame_tick <= commit;
      ccnt       <= ccnt_nxt;
      row        <= row_nxt;
      ROWOUT     <= 16'h0001 << row_nxt;
      COLR       <= col_on ? dbuf_r[row_nxt] : 8'h00;
      COLG       <= col_on ? dbuf_g[row_nxt] : 8'h00;
    end
  end

endmodule

// File: tb/tb_dotmat_frame_scanner.sv
// Directed bench for dotmat_frame_scanner with SWAP_PERIOD=64, ROW_CYCLES=8, BLANK_CYCLES=2.
// n counts rising edges since reset release; outputs are sampled on the falling edge.
module tb_dotmat_frame_scanner;

  logic        CLK;
  logic        RSTn;
  logic [9:0]  pixel_in;
  logic [15:0] ROWOUT;
  logic [7:0]  COLR;
  logic [7:0]  COLG;
  logic        frame_tick;

  int n;
  int compared;
  int mismatched;

  logic [15:0] exp_row;
  logic [7:0]  exp_r;
  logic [7:0]  exp_g;
  logic        exp_t;

  localparam logic [9:0] P_DOT12  = 10'b10_0110_0011;
  localparam logic [9:0] P_NOP12  = 10'b00_0110_0100;
  localparam logic [9:0] P_BOTH   = 10'b11_0001_0111;
  localparam logic [9:0] P_BAR0   = 10'b10_0110_1000;
  localparam logic [9:0] P_BAR1   = 10'b10_0110_1001;
  localparam logic [9:0] P_BAR2   = 10'b10_1110_1010;
  localparam logic [9:0] P_G00    = 10'b01_0000_0000;
  localparam logic [9:0] P_R94    = 10'b10_0100_1100;
  localparam logic [9:0] P_R16    = 10'b10_0000_1110;
  localparam logic [9:0] P_G94    = 10'b01_0100_1100;

  dotmat_frame_scanner #(
    .SWAP_PERIOD (64),
    .ROW_CYCLES  (8),
    .BLANK_CYCLES(2)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .pixel_in  (pixel_in),
    .ROWOUT    (ROWOUT),
    .COLR      (COLR),
    .COLG      (COLG),
    .frame_tick(frame_tick)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic int rowof(input int k);
    return (k / 8) % 16;
  endfunction

  function automatic bit vis(input int k);
`ifdef DOTMAT_BLANK_EN
    return (k % 8) >= 2;
`else
    return 1'b1;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    n++;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    pixel_in = '0;
    RSTn = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    n = 0;
  endtask

  task automatic test_reset();
    pixel_in = '0;
    RSTn = 1'b0;
    #1;
    compared += 4;
    if (ROWOUT !== 16'h0001) begin mismatched++; $display("FAIL reset_rowout got %h want 0001", ROWOUT); end
    if (COLR !== 8'h00) begin mismatched++; $display("FAIL reset_colr got %h want 00", COLR); end
    if (COLG !== 8'h00) begin mismatched++; $display("FAIL reset_colg got %h want 00", COLG); end
    if (frame_tick !== 1'b0) begin mismatched++; $display("FAIL reset_tick got %b want 0", frame_tick); end
    @(negedge CLK);
    RSTn = 1'b1;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      pixel_in = '0;
      tick();
      exp_row = 16'h0001 << rowof(n);
      exp_t   = (n % 64 == 0);
      compared += 4;
      if (ROWOUT !== exp_row) begin mismatched++; $display("FAIL idle_rowout n=%0d got %h want %h", n, ROWOUT, exp_row); end
      if (COLR !== 8'h00) begin mismatched++; $display("FAIL idle_colr n=%0d got %h want 00", n, COLR); end
      if (COLG !== 8'h00) begin mismatched++; $display("FAIL idle_colg n=%0d got %h want 00", n, COLG); end
      if (frame_tick !== exp_t) begin mismatched++; $display("FAIL idle_tick n=%0d got %b want %b", n, frame_tick, exp_t); end
    end
  endtask

  task automatic test_single_dot();
    do_reset();
    for (int k = 0; k < 140; k++) begin
      pixel_in = (n + 1 == 1) ? P_DOT12 : (n + 1 == 5) ? P_NOP12 : 10'd0;
      tick();
      exp_r = (n >= 65 && n <= 128 && rowof(n) == 12 && vis(n)) ? 8'h08 : 8'h00;
      compared += 2;
      if (COLR !== exp_r) begin mismatched++; $display("FAIL dot_colr n=%0d got %h want %h", n, COLR, exp_r); end
      if (COLG !== 8'h00) begin mismatched++; $display("FAIL dot_colg n=%0d got %h want 00", n, COLG); end
    end
  endtask

  task automatic test_both_planes();
    do_reset();
    for (int k = 0; k < 280; k++) begin
      pixel_in = (n + 1 == 70) ? P_BOTH : 10'd0;
      tick();
      exp_r = (n >= 129 && n <= 192 && rowof(n) == 2 && vis(n)) ? 8'h80 : 8'h00;
      compared += 2;
      if (COLR !== exp_r) begin mismatched++; $display("FAIL both_colr n=%0d got %h want %h", n, COLR, exp_r); end
      if (COLG !== exp_r) begin mismatched++; $display("FAIL both_colg n=%0d got %h want %h", n, COLG, exp_r); end
    end
  endtask

  task automatic test_accumulate();
    do_reset();
    for (int k = 0; k < 130; k++) begin
      case (n + 1)
        1:       pixel_in = P_BAR0;
        2:       pixel_in = P_BAR1;
        3:       pixel_in = P_BAR2;
        4:       pixel_in = P_BAR2;
        default: pixel_in = '0;
      endcase
      tick();
      exp_r = (n >= 65 && n <= 128 && rowof(n) == 13 && vis(n)) ? 8'h07 : 8'h00;
      compared += 2;
      if (COLR !== exp_r) begin mismatched++; $display("FAIL bar_colr n=%0d got %h want %h", n, COLR, exp_r); end
      if (COLG !== 8'h00) begin mismatched++; $display("FAIL bar_colg n=%0d got %h want 00", n, COLG); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < 260; k++) begin
      pixel_in = (n + 1 == 128) ? P_G00 : 10'd0;
      tick();
      exp_g = (n >= 193 && n <= 256 && rowof(n) == 0 && vis(n)) ? 8'h01 : 8'h00;
      exp_t = (n % 64 == 0);
      compared += 3;
      if (COLG !== exp_g) begin mismatched++; $display("FAIL simul_colg n=%0d got %h want %h", n, COLG, exp_g); end
      if (COLR !== 8'h00) begin mismatched++; $display("FAIL simul_colr n=%0d got %h want 00", n, COLR); end
      if (frame_tick !== exp_t) begin mismatched++; $display("FAIL simul_tick n=%0d got %b want %b", n, frame_tick, exp_t); end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int k = 0; k < 75; k++) begin
      case (n + 1)
        1:       pixel_in = P_R94;
        2:       pixel_in = P_R16;
        74:      pixel_in = P_G94;
        default: pixel_in = '0;
      endcase
      tick();
      exp_r = (n >= 65 && rowof(n) == 9 && vis(n)) ? 8'h10 : 8'h00;
      compared += 1;
      if (COLR !== exp_r) begin mismatched++; $display("FAIL pre_colr n=%0d got %h want %h", n, COLR, exp_r); end
    end
    pixel_in = '0;
    RSTn = 1'b0;
    #1;
    compared += 4;
    if (ROWOUT !== 16'h0001) begin mismatched++; $display("FAIL mid_rowout got %h want 0001", ROWOUT); end
    if (COLR !== 8'h00) begin mismatched++; $display("FAIL mid_colr got %h want 00", COLR); end
    if (COLG !== 8'h00) begin mismatched++; $display("FAIL mid_colg got %h want 00", COLG); end
    if (frame_tick !== 1'b0) begin mismatched++; $display("FAIL mid_tick got %b want 0", frame_tick); end
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    n = 0;
    for (int k = 0; k < 130; k++) begin
      tick();
      exp_row = 16'h0001 << rowof(n);
      exp_t   = (n % 64 == 0);
      compared += 4;
      if (ROWOUT !== exp_row) begin mismatched++; $display("FAIL post_rowout n=%0d got %h want %h", n, ROWOUT, exp_row); end
      if (COLR !== 8'h00) begin mismatched++; $display("FAIL post_colr n=%0d got %h want 00", n, COLR); end
      if (COLG !== 8'h00) begin mismatched++; $display("FAIL post_colg n=%0d got %h want 00", n, COLG); end
      if (frame_tick !== exp_t) begin mismatched++; $display("FAIL post_tick n=%0d got %b want %b", n, frame_tick, exp_t); end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    n          = 0;
    RSTn       = 1'b0;
    pixel_in   = '0;
    @(negedge CLK);
    test_reset();
    test_single_dot();
    test_both_planes();
    test_accumulate();
    test_simultaneous();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dotmat_frame_scanner.md
# dotmat_frame_scanner

Downstream stage of the game core: it consumes the core's time-multiplexed 10-bit pixel stream (one lit dot per clock) and turns it into a steady 16-row × 8-column two-colour LED matrix image. Dots are accumulated into a write buffer, which is committed to a display buffer once per frame period. The display buffer is scanned row by row onto one-hot row drivers and red/green column drivers.

## Interface
- SWAP_PERIOD, 256128, clocks per frame commit; one full game-core display cycle is 128 × 2001.
- ROW_CYCLES, 1024, clocks each row is driven.
- BLANK_CYCLES, 64, clocks at the start of each row with all columns off; must be < ROW_CYCLES.

Ports:
- CLK  input  1  system clock; one clock.
- RSTn  input  1  reset, asynchronous, active-low.
- pixel_in  input  10  dot command:
  - [9] red plane, [8] green plane, [7] ignored.
  - [6:3] row y, [2:0] column x.
  - A value with [9:8]=00 writes nothing.
- ROWOUT  output  16  one-hot row select; bit n drives row n.
- COLR  output  8  red column data for the selected row; bit x = column x.
- COLG  output  8  green column data for the selected row.
- frame_tick  output  1  one-cycle pulse on each commit cycle.

## Operation
- Storage:
  - wbuf_r/wbuf_g: write buffer, 16 × 8 bits per plane.
  - dbuf_r/dbuf_g: display buffer, 16 × 8 bits per plane.
- Pixel write: every clock, if pixel_in[9], set wbuf_r[y][x]; if pixel_in[8], set wbuf_g[y][x].
  - Writes are OR-only; a dot is never cleared by a later pixel.
  - The same dot repeated in consecutive cycles is idempotent.
- Frame counter fcnt:
  - Counts 0..SWAP_PERIOD-1 and wraps.
  - Commit cycle is fcnt == SWAP_PERIOD-1.
- On the commit cycle:
  - dbuf <= wbuf for both planes.
  - wbuf is cleared to all zero.
  - frame_tick = 1.
- Simultaneous pixel and commit: a pixel arriving on the commit cycle is written into the freshly cleared wbuf only. It is not part of the committed frame.
- Scan counters:
  - ccnt counts 0..ROW_CYCLES-1.
  - On wrap, row advances 0→1→…→15→0.
- Row output: ROWOUT = 1 << row.
- Column output:
  - During ccnt < BLANK_CYCLES: COLR = COLG = 0.
  - Otherwise: COLR = dbuf_r[row], COLG = dbuf_g[row].
- Scan and commit are independent. A commit mid-row changes the columns immediately, with the output latency below, and does not disturb row or ccnt.
- Reset, asynchronous, including mid-frame:
  - All buffers and counters go to 0.
  - ROWOUT = 16'h0001, COLR = COLG = 0, frame_tick = 0.

## Timing
- All outputs are registered.
- pixel_in sampled at edge k is in wbuf after edge k. It becomes visible only after the next commit edge plus one cycle of output latency.
- A commit at edge k:
  - frame_tick is high for the cycle following edge k.
  - The new dbuf appears on COLR/COLG from edge k+1.
- Row change:
  - ROWOUT switches on the edge where ccnt wraps to 0.
  - Columns are 0 for exactly BLANK_CYCLES cycles starting at that same edge.
- First commit after reset occurs SWAP_PERIOD clocks after RSTn deasserts; frame_tick repeats every SWAP_PERIOD clocks.
- Full scan period: 16 × ROW_CYCLES clocks.

## Configuration
- Macro `DOTMAT_BLANK_EN`.
- Defined: inter-row column blanking for BLANK_CYCLES, as above.
- Undefined:
  - No blanking; columns show dbuf[row] for all ROW_CYCLES cycles.
  - The BLANK_CYCLES parameter is ignored.
  - ROWOUT and commit behaviour are identical in both builds.

## Test plan
Benches use SWAP_PERIOD=64, ROW_CYCLES=8, BLANK_CYCLES=2.

1. Reset, then hold pixel_in=0 for 200 clocks:
   - ROWOUT walks 0001→0002→…→8000→0001 every 8 clocks.
   - COLR = COLG = 0 throughout.
   - frame_tick pulses at clocks 64, 128 and 192.
2. Single dot: pixel_in=10'b10_0110_0011 (red, y=12, x=3) for one cycle, then 0.
   - Before commit: no output.
   - After commit, when ROWOUT=16'h1000: COLR=8'h08 for cycles 2..7 of the row, 0 for cycles 0..1; COLG=0.
3. Both planes: pixel_in=10'b11_0001_0111 (y=2, x=7).
   - Row 2 shows COLR = COLG = 8'h80 in the following frame.
   - The frame after that shows 0 in row 2 if the dot is not repeated.
4. Accumulate bar: three consecutive writes of 10'b10_0110_1000/…_1001/…_1010 (y=13, x=0..2).
   - After commit, row 13 shows COLR = 8'h07.
5. Simultaneous events: pixel_in=10'b01_0000_0000 (green, y=0, x=0) exactly on the commit cycle.
   - Absent from the frame just committed.
   - Row 0 shows COLG=8'h01 after the next commit.
6. Reset mid-frame: assert RSTn=0 while row=9 with a committed image.
   - Outputs go immediately to ROWOUT=16'h0001, COLR=COLG=0, frame_tick=0.
   - After release, the first frame_tick arrives 64 clocks later with a blank image.
